// File: rtl/pwm_pkg.sv
// Shared helpers for the PWM bank: counter limits, channel phase staggering,
// channel-select width and the enums used by the duty-update logic.
package pwm_pkg;

    typedef enum logic [1:0] {
        OP_HOLD,
        OP_UP,
        OP_DN
    } duty_op_e;

    function automatic int unsigned pwm_max(input int unsigned width);
        return (32'd1 << width) - 32'd1;
    endfunction

    // Channels are spread evenly over one counter period so their edges do not align.
    function automatic int unsigned phase_offset(input int unsigned ch,
                                                 input int unsigned n_ch,
                                                 input int unsigned width);
        return ch * ((32'd1 << width) / n_ch);
    endfunction

    function automatic int unsigned sel_width(input int unsigned n_ch);
        return (n_ch > 1) ? $clog2(n_ch) : 1;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser, persistence debouncer and press-pulse generator for
// one active-low push button.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_MAX = 540_000
) (
    input  logic clk,
    input  logic reset_in,
    input  logic btn_n,
    output logic press
);

    localparam int unsigned CNT_W = (DEBOUNCE_MAX > 1) ? $clog2(DEBOUNCE_MAX + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_MAX - 1);

    logic [1:0]       sync;
    logic [CNT_W-1:0] count;
    logic             level;

    // The button is inverted before the synchroniser so that the cleared reset
    // state reads as "released" and cannot fake a press after reset.
    always_ff @(posedge clk or posedge reset_in) begin
        if (reset_in) begin
            sync  <= '0;
            count <= '0;
            level <= 1'b0;
            press <= 1'b0;
        end else begin
            sync  <= {sync[0], ~btn_n};
            press <= 1'b0;
            if (sync[1] != level) begin
                if (count == CNT_LAST) begin
                    count <= '0;
                    level <= sync[1];
                    press <= sync[1];
                end else begin
                    count <= count + CNT_W'(1);
                end
            end else begin
                count <= '0;
            end
        end
    end

endmodule

// File: rtl/pwm_bank.sv
// Bank of phase-staggered PWM channels whose duties are adjusted from three
// debounced push buttons (channel select, duty up, duty down).
module pwm_bank
    import pwm_pkg::*;
#(
    parameter int unsigned N_CH         = 4,
    parameter int unsigned WIDTH        = 8,
    parameter int unsigned STEP         = 10,
    parameter int unsigned DEBOUNCE_MAX = 540_000,
    parameter bit          WRAP         = 1'b1
) (
    input  logic                          clk,
    input  logic                          reset_in,
    input  logic                          btn_sel_n,
    input  logic                          btn_up_n,
    input  logic                          btn_dn_n,
    output logic [N_CH-1:0]               pwm_out,
    output logic [sel_width(N_CH)-1:0]    sel_ch,
    output logic [WIDTH-1:0]              duty_sel,
    output logic                          period_start
);

    localparam int unsigned       SEL_W   = sel_width(N_CH);
    localparam logic [WIDTH-1:0]  MAX_V   = WIDTH'(pwm_max(WIDTH));
    localparam logic [WIDTH:0]    STEP_W  = (WIDTH + 1)'(STEP);
    localparam logic [SEL_W-1:0]  LAST_CH = SEL_W'(N_CH - 1);

    logic             sel_press;
    logic             up_press;
    logic             dn_press;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] target_duty [N_CH];
    logic [WIDTH-1:0] active_duty [N_CH];
    logic [WIDTH-1:0] phase       [N_CH];
    logic [WIDTH-1:0] cur_duty;
    logic [WIDTH-1:0] next_duty;
    logic [WIDTH:0]   sum;
    duty_op_e         op;

    btn_debounce #(.DEBOUNCE_MAX(DEBOUNCE_MAX)) u_sel_btn (
        .clk      (clk),
        .reset_in (reset_in),
        .btn_n    (btn_sel_n),
        .press    (sel_press)
    );

    btn_debounce #(.DEBOUNCE_MAX(DEBOUNCE_MAX)) u_up_btn (
        .clk      (clk),
        .reset_in (reset_in),
        .btn_n    (btn_up_n),
        .press    (up_press)
    );

    btn_debounce #(.DEBOUNCE_MAX(DEBOUNCE_MAX)) u_dn_btn (
        .clk      (clk),
        .reset_in (reset_in),
        .btn_n    (btn_dn_n),
        .press    (dn_press)
    );

    // Simultaneous up and down presses cancel each other.
    always_comb begin
        op = OP_HOLD;
        if (up_press && !dn_press) begin
            op = OP_UP;
        end else if (dn_press && !up_press) begin
            op = OP_DN;
        end
    end

    always_comb begin
        cur_duty  = target_duty[sel_ch];
        sum       = {1'b0, cur_duty} + STEP_W;
        next_duty = cur_duty;
        case (op)
            OP_UP: begin
                if (sum > {1'b0, MAX_V}) begin
                    next_duty = WRAP ? '0 : MAX_V;
                end else begin
                    next_duty = sum[WIDTH-1:0];
                end
            end
            OP_DN: begin
                if ({1'b0, cur_duty} < STEP_W) begin
                    next_duty = WRAP ? MAX_V : '0;
                end else begin
                    next_duty = cur_duty - STEP_W[WIDTH-1:0];
                end
            end
            default: next_duty = cur_duty;
        endcase
    end

    always_ff @(posedge clk or posedge reset_in) begin
        if (reset_in) begin
            cnt          <= '0;
            period_start <= 1'b0;
        end else begin
            cnt          <= cnt + WIDTH'(1);
            period_start <= (cnt == '0);
        end
    end

    always_ff @(posedge clk or posedge reset_in) begin
        if (reset_in) begin
            sel_ch <= '0;
        end else if (sel_press) begin
            sel_ch <= (sel_ch == LAST_CH) ? '0 : sel_ch + SEL_W'(1);
        end
    end

    // Edits land in the target duty; the active copy only follows at the end of
    // a period so a running pulse is never cut short or stretched.
    always_ff @(posedge clk or posedge reset_in) begin
        if (reset_in) begin
            for (int ch = 0; ch < N_CH; ch++) begin
                target_duty[ch] <= '0;
                active_duty[ch] <= '0;
            end
        end else begin
            for (int ch = 0; ch < N_CH; ch++) begin
                if (op != OP_HOLD && SEL_W'(ch) == sel_ch) begin
                    target_duty[ch] <= next_duty;
                end
                if (cnt == MAX_V) begin
                    active_duty[ch] <= target_duty[ch];
                end
            end
        end
    end

    always_comb begin
        for (int ch = 0; ch < N_CH; ch++) begin
            phase[ch] = cnt + WIDTH'(phase_offset(ch, N_CH, WIDTH));
        end
    end

    always_ff @(posedge clk or posedge reset_in) begin
        if (reset_in) begin
            pwm_out <= '0;
        end else begin
            for (int ch = 0; ch < N_CH; ch++) begin
                pwm_out[ch] <= (phase[ch] < active_duty[ch]);
            end
        end
    end

    assign duty_sel = active_duty[sel_ch];

endmodule

// File: tb/tb_pwm_bank.sv
// Directed bench for pwm_bank: one wrapping and one saturating instance share
// the same clock, reset and button stimulus.
module tb_pwm_bank;

    logic       clk = 1'b0;
    logic       reset_in;
    logic       btn_sel_n;
    logic       btn_up_n;
    logic       btn_dn_n;

    logic [3:0] w1_pwm_out;
    logic [1:0] w1_sel_ch;
    logic [7:0] w1_duty_sel;
    logic       w1_period_start;
    logic [3:0] w0_pwm_out;
    logic [1:0] w0_sel_ch;
    logic [7:0] w0_duty_sel;
    logic       w0_period_start;

    int compared   = 0;
    int mismatched = 0;

    pwm_bank #(.N_CH(4), .WIDTH(8), .STEP(10), .DEBOUNCE_MAX(4), .WRAP(1'b1)) u_wrap (
        .clk          (clk),
        .reset_in     (reset_in),
        .btn_sel_n    (btn_sel_n),
        .btn_up_n     (btn_up_n),
        .btn_dn_n     (btn_dn_n),
        .pwm_out      (w1_pwm_out),
        .sel_ch       (w1_sel_ch),
        .duty_sel     (w1_duty_sel),
        .period_start (w1_period_start)
    );

    pwm_bank #(.N_CH(4), .WIDTH(8), .STEP(10), .DEBOUNCE_MAX(4), .WRAP(1'b0)) u_sat (
        .clk          (clk),
        .reset_in     (reset_in),
        .btn_sel_n    (btn_sel_n),
        .btn_up_n     (btn_up_n),
        .btn_dn_n     (btn_dn_n),
        .pwm_out      (w0_pwm_out),
        .sel_ch       (w0_sel_ch),
        .duty_sel     (w0_duty_sel),
        .period_start (w0_period_start)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press_buttons(input logic sel, input logic up, input logic dn,
                                 input int hold);
        btn_sel_n = ~sel;
        btn_up_n  = ~up;
        btn_dn_n  = ~dn;
        tick(hold);
        btn_sel_n = 1'b1;
        btn_up_n  = 1'b1;
        btn_dn_n  = 1'b1;
        tick(10);
    endtask

    // Returns at the sample where period_start is high, i.e. just after a duty copy.
    task automatic wait_period();
        int k = 0;
        do begin
            tick(1);
            k++;
        end while (!w1_period_start && k < 300);
        check_output("period_wait", {31'd0, w1_period_start}, 32'd1);
    endtask

    // Expects to be called at the negedge where reset_in has just been released.
    task automatic post_reset_checks(input string tag);
        int ps_count = 0;
        int ps_first = -1;
        logic [3:0] pwm_or = '0;
        for (int i = 0; i < 256; i++) begin
            tick(1);
            if (w1_period_start) begin
                ps_count++;
                if (ps_first < 0) ps_first = i;
            end
            pwm_or |= w1_pwm_out | w0_pwm_out;
        end
        check_output({tag, "_ps_count"}, ps_count, 32'd1);
        check_output({tag, "_ps_first"}, ps_first, 32'd0);
        check_output({tag, "_pwm_quiet"}, {28'd0, pwm_or}, 32'd0);
        check_output({tag, "_sel"}, {30'd0, w1_sel_ch}, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: observed timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int hi0, hi1, r0, r1, hi2;
        logic p0, p1;
        logic [1:0] idle_or;

        reset_in  = 1'b1;
        btn_sel_n = 1'b1;
        btn_up_n  = 1'b1;
        btn_dn_n  = 1'b1;
        tick(3);
        check_output("rst_pwm", {28'd0, w1_pwm_out | w0_pwm_out}, 32'd0);
        check_output("rst_sel", {30'd0, w1_sel_ch}, 32'd0);
        check_output("rst_duty", {24'd0, w1_duty_sel}, 32'd0);
        check_output("rst_ps", {31'd0, w1_period_start}, 32'd0);
        reset_in = 1'b0;
        post_reset_checks("init");

        // A 3-cycle blip is too short to debounce.
        wait_period();
        press_buttons(1'b0, 1'b1, 1'b0, 3);
        wait_period();
        check_output("glitch_duty", {24'd0, w1_duty_sel}, 32'd0);

        // A 6-cycle hold is one press; it only shows after the period boundary.
        wait_period();
        press_buttons(1'b0, 1'b1, 1'b0, 6);
        check_output("midperiod_duty", {24'd0, w1_duty_sel}, 32'd0);
        wait_period();
        check_output("press_duty_w1", {24'd0, w1_duty_sel}, 32'd10);
        check_output("press_duty_w0", {24'd0, w0_duty_sel}, 32'd10);

        // ch0 and ch1 to 60 each, then compare their waveforms.
        for (int i = 0; i < 5; i++) press_buttons(1'b0, 1'b1, 1'b0, 6);
        press_buttons(1'b1, 1'b0, 1'b0, 6);
        check_output("sel_to_1", {30'd0, w1_sel_ch}, 32'd1);
        for (int i = 0; i < 6; i++) press_buttons(1'b0, 1'b1, 1'b0, 6);
        wait_period();
        check_output("ch1_duty", {24'd0, w1_duty_sel}, 32'd60);

        hi0 = 0; hi1 = 0; r0 = -1000; r1 = -1000;
        p0 = w1_pwm_out[0];
        p1 = w1_pwm_out[1];
        idle_or = '0;
        for (int i = 0; i < 512; i++) begin
            tick(1);
            if (i < 256) begin
                hi0 += int'(w1_pwm_out[0]);
                hi1 += int'(w1_pwm_out[1]);
            end
            if (!p0 && w1_pwm_out[0] && r0 < 0) r0 = i;
            if (!p1 && w1_pwm_out[1] && r1 < 0) r1 = i;
            p0 = w1_pwm_out[0];
            p1 = w1_pwm_out[1];
            idle_or |= w1_pwm_out[3:2];
        end
        check_output("ch0_high_cycles", hi0, 32'd60);
        check_output("ch1_high_cycles", hi1, 32'd60);
        check_output("ch1_rise_lag", ((r1 - r0) % 256 + 256) % 256, 32'd192);
        check_output("idle_ch_quiet", {30'd0, idle_or}, 32'd0);

        // Select wraps 3 -> 0.
        press_buttons(1'b1, 1'b0, 1'b0, 6);
        check_output("sel_seq_2", {30'd0, w1_sel_ch}, 32'd2);
        press_buttons(1'b1, 1'b0, 1'b0, 6);
        check_output("sel_seq_3", {30'd0, w1_sel_ch}, 32'd3);
        press_buttons(1'b1, 1'b0, 1'b0, 6);
        check_output("sel_seq_0", {30'd0, w1_sel_ch}, 32'd0);
        press_buttons(1'b1, 1'b0, 1'b0, 6);
        press_buttons(1'b1, 1'b0, 1'b0, 6);
        check_output("sel_seq_back_2", {30'd0, w1_sel_ch}, 32'd2);

        // Select and up together: the edit goes to the channel selected before.
        press_buttons(1'b1, 1'b1, 1'b0, 6);
        check_output("sel_up_sel", {30'd0, w1_sel_ch}, 32'd3);
        for (int i = 0; i < 3; i++) press_buttons(1'b1, 1'b0, 1'b0, 6);
        check_output("sel_up_back_2", {30'd0, w1_sel_ch}, 32'd2);
        wait_period();
        check_output("sel_up_duty", {24'd0, w1_duty_sel}, 32'd10);

        press_buttons(1'b0, 1'b1, 1'b1, 6);
        wait_period();
        check_output("up_dn_cancel", {24'd0, w1_duty_sel}, 32'd10);

        // Down past zero: wrap to MAX versus clamp at 0.
        press_buttons(1'b0, 1'b0, 1'b1, 6);
        wait_period();
        check_output("dn_to_0_w1", {24'd0, w1_duty_sel}, 32'd0);
        check_output("dn_to_0_w0", {24'd0, w0_duty_sel}, 32'd0);
        press_buttons(1'b0, 1'b0, 1'b1, 6);
        wait_period();
        check_output("dn_under_w1", {24'd0, w1_duty_sel}, 32'd255);
        check_output("dn_under_w0", {24'd0, w0_duty_sel}, 32'd0);
        hi2 = 0;
        for (int i = 0; i < 256; i++) begin
            tick(1);
            hi2 += int'(w1_pwm_out[2]);
        end
        check_output("max_duty_high", hi2, 32'd255);

        // Up past MAX on ch3: wrap to 0 versus clamp at MAX.
        press_buttons(1'b1, 1'b0, 1'b0, 6);
        check_output("sel_to_3", {30'd0, w1_sel_ch}, 32'd3);
        for (int i = 0; i < 25; i++) press_buttons(1'b0, 1'b1, 1'b0, 6);
        wait_period();
        check_output("up_to_250", {24'd0, w0_duty_sel}, 32'd250);
        press_buttons(1'b0, 1'b1, 1'b0, 6);
        wait_period();
        check_output("up_over_w1", {24'd0, w1_duty_sel}, 32'd0);
        check_output("up_over_w0", {24'd0, w0_duty_sel}, 32'd255);

        // Asynchronous reset in the middle of a period with live duties.
        wait_period();
        tick(30);
        check_output("pre_reset_pwm0", {31'd0, w1_pwm_out[0]}, 32'd1);
        #2 reset_in = 1'b1;
        #1;
        check_output("async_rst_pwm", {28'd0, w1_pwm_out | w0_pwm_out}, 32'd0);
        check_output("async_rst_duty", {24'd0, w0_duty_sel}, 32'd0);
        check_output("async_rst_sel", {30'd0, w0_sel_ch}, 32'd0);
        check_output("async_rst_ps", {31'd0, w0_period_start}, 32'd0);
        tick(3);
        reset_in = 1'b0;
        post_reset_checks("midrst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
